// File: rtl/stack_sequencer.sv
// Stack-pointer sequencer: turns PUSH/POP/CALL/RET requests into data-memory strobes.
// Optional STACK_ERR_STICKY_EN adds err_clr/err_status sticky error reporting.
module stack_sequencer #(
    parameter logic [7:0] SP_INIT     = 8'hFF,
    parameter int         STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [1:0] op_code,
    input  logic [7:0] mem_rdata,
    output logic [7:0] sp_out,
    output logic       s2,
    output logic       s5,
    output logic       wr,
    output logic       rd,
    output logic [7:0] pop_data,
    output logic       pc_load,
    output logic       done,
    output logic       err_ovf,
    output logic       err_unf,
`ifdef STACK_ERR_STICKY_EN
    input  logic       err_clr,
    output logic [1:0] err_status,
`endif
    output logic [7:0] depth
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;
    localparam logic [7:0] DEPTH_MAX = 8'(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        INC    = 3'd2,
        READ   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t     state_reg;
    logic [1:0] op_reg;
    logic       ready_ok;

    // A pending sticky error keeps the sequencer closed until it is cleared.
`ifdef STACK_ERR_STICKY_EN
    assign ready_ok = err_clr || (err_status == 2'b00);
`else
    assign ready_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_PUSH;
            op_ready  <= 1'b1;
            sp_out    <= SP_INIT;
            depth     <= 8'd0;
            pop_data  <= 8'd0;
            s2        <= 1'b0;
            s5        <= 1'b0;
            wr        <= 1'b0;
            rd        <= 1'b0;
            done      <= 1'b0;
            pc_load   <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
`ifdef STACK_ERR_STICKY_EN
            err_status <= 2'b00;
`endif
        end else begin
            s2      <= 1'b0;
            s5      <= 1'b0;
            wr      <= 1'b0;
            rd      <= 1'b0;
            done    <= 1'b0;
            pc_load <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
`ifdef STACK_ERR_STICKY_EN
            if (err_clr) begin
                err_status <= 2'b00;
            end
`endif
            case (state_reg)
                IDLE: begin
                    if (!op_ready && ready_ok) begin
                        op_ready <= 1'b1;
                    end
                    if (op_valid && op_ready) begin
                        op_reg   <= op_code;
                        op_ready <= 1'b0;
                        if (op_code == OP_PUSH || op_code == OP_CALL) begin
                            if (depth < DEPTH_MAX) begin
                                state_reg <= WRITE;
                                s2        <= 1'b1;
                                wr        <= 1'b1;
                                s5        <= (op_code == OP_PUSH);
                            end else begin
                                state_reg <= FINISH;
                                done      <= 1'b1;
                                err_ovf   <= 1'b1;
`ifdef STACK_ERR_STICKY_EN
                                err_status[1] <= 1'b1;
`endif
                            end
                        end else begin
                            if (depth != 8'd0) begin
                                state_reg <= INC;
                            end else begin
                                state_reg <= FINISH;
                                done      <= 1'b1;
                                err_unf   <= 1'b1;
`ifdef STACK_ERR_STICKY_EN
                                err_status[0] <= 1'b1;
`endif
                            end
                        end
                    end
                end
                WRITE: begin
                    // Memory captures at the old SP on this edge.
                    sp_out    <= sp_out - 8'd1;
                    depth     <= depth + 8'd1;
                    state_reg <= FINISH;
                    done      <= 1'b1;
                end
                INC: begin
                    sp_out    <= sp_out + 8'd1;
                    depth     <= depth - 8'd1;
                    state_reg <= READ;
                    s2        <= 1'b1;
                    rd        <= 1'b1;
                end
                READ: begin
                    pop_data  <= mem_rdata;
                    state_reg <= FINISH;
                    done      <= 1'b1;
                    pc_load   <= (op_reg == OP_RET);
                end
                FINISH: begin
                    state_reg <= IDLE;
                    op_ready  <= ready_ok;
                end
                default: begin
                    state_reg <= IDLE;
                    op_ready  <= 1'b1;
                end
            endcase
        end
    end

    // OP_POP is decoded implicitly as "not a push-type op".
    logic unused_ok;
    assign unused_ok = (OP_POP == 2'b01);

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboarded bench for stack_sequencer with a behavioural data memory and a reference stack.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] op_code = 2'b00;
    logic [7:0] mem_rdata;
    logic [7:0] sp_out;
    logic       s2, s5, wr, rd;
    logic [7:0] pop_data;
    logic       pc_load, done, err_ovf, err_unf;
    logic [7:0] depth;
`ifdef STACK_ERR_STICKY_EN
    logic       err_clr = 1'b0;
    logic [1:0] err_status;
`endif

    int total = 0;
    int bad   = 0;

    stack_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .mem_rdata(mem_rdata), .sp_out(sp_out), .s2(s2), .s5(s5), .wr(wr), .rd(rd),
        .pop_data(pop_data), .pc_load(pc_load), .done(done), .err_ovf(err_ovf),
        .err_unf(err_unf),
`ifdef STACK_ERR_STICKY_EN
        .err_clr(err_clr), .err_status(err_status),
`endif
        .depth(depth)
    );

    always #5 clk = ~clk;

    // Mock data memory: RN / NPC sources, write on the edge, combinational read.
    logic [7:0] mem [256];
    logic [7:0] rn  = 8'h00;
    logic [7:0] npc = 8'h00;
    always @(posedge clk) begin
        if (wr && s2) mem[sp_out] <= s5 ? rn : npc;
    end
    assign mem_rdata = mem[sp_out];

    typedef struct {
        int         lat;
        logic       wr_exp;
        logic       rd_exp;
        logic [7:0] wr_addr;
        logic       s5_exp;
        logic [7:0] pop;
        logic       pcl;
        logic       ovf;
        logic       unf;
        logic [7:0] sp;
        logic [7:0] dep;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_stack[$];
    logic [7:0] m_sp    = 8'hFF;
    logic [7:0] m_depth = 8'd0;
    logic [7:0] m_pop   = 8'd0;

    task automatic model_reset();
        m_sp = 8'hFF; m_depth = 8'd0; m_pop = 8'd0;
        m_stack.delete();
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic do_op(input logic [1:0] code, input logic [7:0] data);
        exp_t e;
        exp_t g;
        int   n;
        int   wr_cnt, rd_cnt;
        logic [7:0] wr_addr_seen;
        logic       s5_seen;
        logic       got;
        e = '{lat: 1, wr_exp: 0, rd_exp: 0, wr_addr: 8'h00, s5_exp: 0, pop: 8'h00,
              pcl: 0, ovf: 0, unf: 0, sp: 8'h00, dep: 8'h00};
        if (code == 2'b00 || code == 2'b10) begin
            if (m_depth < 8'd16) begin
                e.lat = 2; e.wr_exp = 1; e.wr_addr = m_sp; e.s5_exp = (code == 2'b00);
                m_stack.push_back(data);
                m_sp = m_sp - 8'd1; m_depth = m_depth + 8'd1;
            end else begin
                e.ovf = 1;
            end
        end else begin
            if (m_depth > 8'd0) begin
                e.lat = 3; e.rd_exp = 1;
                m_sp = m_sp + 8'd1; m_depth = m_depth - 8'd1;
                m_pop = m_stack.pop_back();
                e.pcl = (code == 2'b11);
            end else begin
                e.unf = 1;
            end
        end
        e.pop = m_pop; e.sp = m_sp; e.dep = m_depth;
        sb.push_back(e);

        if (code == 2'b10) npc = data; else rn = data;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = op_ready;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL ready_timeout op=%0d op_ready=%b required 1", code, op_ready);
            void'(sb.pop_front());
            return;
        end
        op_code = code; op_valid = 1'b1;
        @(posedge clk); #1 op_valid = 1'b0;

        wr_cnt = 0; rd_cnt = 0; wr_addr_seen = 8'h00; s5_seen = 1'b0; n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            if (wr) begin wr_cnt++; wr_addr_seen = sp_out; s5_seen = s5; end
            if (rd) rd_cnt++;
            total++;
            if (wr && rd) begin bad++; $display("FAIL wr_rd_overlap wr=%b rd=%b", wr, rd); end
            got = done;
        end
        g = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL done_timeout op=%0d done=%b required 1", code, done);
            return;
        end
        $display("op=%0d data=%h lat=%0d sp=%h depth=%0d pop=%h pcl=%b ovf=%b unf=%b",
                 code, data, n, sp_out, depth, pop_data, pc_load, err_ovf, err_unf);
        total++; if (n !== g.lat) begin bad++; $display("FAIL latency got=%0d exp=%0d", n, g.lat); end
        total++; if (pop_data !== g.pop) begin bad++; $display("FAIL pop_data got=%h exp=%h", pop_data, g.pop); end
        total++; if (pc_load !== g.pcl) begin bad++; $display("FAIL pc_load got=%b exp=%b", pc_load, g.pcl); end
        total++; if (err_ovf !== g.ovf) begin bad++; $display("FAIL err_ovf got=%b exp=%b", err_ovf, g.ovf); end
        total++; if (err_unf !== g.unf) begin bad++; $display("FAIL err_unf got=%b exp=%b", err_unf, g.unf); end
        total++; if (sp_out !== g.sp) begin bad++; $display("FAIL sp_out got=%h exp=%h", sp_out, g.sp); end
        total++; if (depth !== g.dep) begin bad++; $display("FAIL depth got=%0d exp=%0d", depth, g.dep); end
        total++; if (wr_cnt !== int'(g.wr_exp)) begin bad++; $display("FAIL wr_count got=%0d exp=%0d", wr_cnt, g.wr_exp); end
        total++; if (rd_cnt !== int'(g.rd_exp)) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", rd_cnt, g.rd_exp); end
        if (g.wr_exp) begin
            total++; if (wr_addr_seen !== g.wr_addr) begin bad++; $display("FAIL write_addr got=%h exp=%h", wr_addr_seen, g.wr_addr); end
            total++; if (s5_seen !== g.s5_exp) begin bad++; $display("FAIL write_s5 got=%b exp=%b", s5_seen, g.s5_exp); end
        end
`ifdef STACK_ERR_STICKY_EN
        if (g.ovf || g.unf) begin
            total++; if (err_status !== {g.ovf, g.unf}) begin bad++; $display("FAIL err_status_set got=%b exp=%b", err_status, {g.ovf, g.unf}); end
            @(negedge clk);
            total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL ready_blocked got=%b exp=0", op_ready); end
            total++; if (err_status !== {g.ovf, g.unf}) begin bad++; $display("FAIL err_status_hold got=%b exp=%b", err_status, {g.ovf, g.unf}); end
            err_clr = 1'b1;
            @(posedge clk); #1 err_clr = 1'b0;
            @(negedge clk);
            total++; if (err_status !== 2'b00) begin bad++; $display("FAIL err_status_clr got=%b exp=00", err_status); end
            total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL ready_after_clr got=%b exp=1", op_ready); end
        end
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (sp_out !== 8'hFF) begin bad++; $display("FAIL reset_sp got=%h exp=ff", sp_out); end
        total++; if (depth !== 8'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
        total++; if ({s2, s5, wr, rd, done, pc_load, err_ovf, err_unf} !== 8'h00) begin
            bad++; $display("FAIL reset_strobes got=%b exp=00000000", {s2, s5, wr, rd, done, pc_load, err_ovf, err_unf});
        end
        total++; if (pop_data !== 8'h00) begin bad++; $display("FAIL reset_pop got=%h exp=00", pop_data); end
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic test_push();
        do_op(2'b00, 8'h5A);
    endtask

    task automatic test_call_ret();
        do_op(2'b10, 8'h23);
        do_op(2'b11, 8'h00);
    endtask

    task automatic test_underflow();
        apply_reset();
        do_op(2'b01, 8'h00);
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 17; i++) do_op(2'b00, 8'(8'h10 + i));
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        seen = 0;
        @(negedge clk);
        op_code = 2'b01; op_valid = 1'b1;
        @(posedge clk); #1 op_valid = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = rd;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL read_not_reached rd=%b exp=1", rd); end
        #2 rst = 1'b1;
        #1;
        $display("reset mid-read: sp=%h depth=%0d rd=%b s2=%b ready=%b", sp_out, depth, rd, s2, op_ready);
        total++; if (sp_out !== 8'hFF) begin bad++; $display("FAIL midrst_sp got=%h exp=ff", sp_out); end
        total++; if (depth !== 8'd0) begin bad++; $display("FAIL midrst_depth got=%0d exp=0", depth); end
        total++; if ({rd, s2, done} !== 3'b000) begin bad++; $display("FAIL midrst_strobes got=%b exp=000", {rd, s2, done}); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", op_ready); end
        @(negedge clk); rst = 1'b0;
        model_reset();
        do_op(2'b00, 8'hC3);
    endtask

    task automatic test_back_to_back();
        logic [1:0] c;
        for (int i = 0; i < 24; i++) begin
            c = (i < 4) ? 2'b00 : 2'($urandom_range(0, 3));
            do_op(c, 8'($urandom_range(0, 255)));
        end
        while (m_depth > 0) do_op(2'b01, 8'h00);
        do_op(2'b11, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_push();
        test_call_ret();
        test_underflow();
        test_overflow();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
